// File: rtl/riscv_mc_ctrl_if.sv
// Control/status bundle between the multicycle datapath and its main control FSM.
// The master side is the controller: it reads instruction fields and the ALU zero
// flag and drives every select and write enable of the datapath.
interface riscv_mc_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       zero;
    logic       pc_we;
    logic       adr_src;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] res_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7_b5, zero,
        output pc_we, adr_src, ir_we, mem_we, reg_we, res_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, state, illegal
    );

    modport slave (
        output opcode, funct3, funct7_b5, zero,
        input  pc_we, adr_src, ir_we, mem_we, reg_we, res_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, state, illegal
    );
endinterface

// File: rtl/riscv_mc_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Optional feature macro: RISCV_MC_ILLEGAL_TRAP_EN -- when defined, an unsupported
// opcode parks the FSM in HALT and raises a sticky illegal flag until reset;
// when undefined, unsupported opcodes execute as a NOP.
module riscv_mc_ctrl (
    input  logic              clk,
    input  logic              rst,
    riscv_mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // funct7_b5 only selects subtract for register-register ops; for addi
    // that bit belongs to the immediate and must be ignored.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_rtype);
        logic [2:0] op;
        case (f3)
            3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t state_q;
    state_t state_d;
    state_t out_sel;

    logic       pc_we;
    logic       adr_src;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] res_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_ctrl;

    // State register; reset always returns to FETCH, even from HALT.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state selection from the current step and the decoded opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is asserted the datapath sees FETCH selects with all enables off.
    assign out_sel = rst ? S_FETCH : state_q;

    // Per-step datapath selects and enables; everything not driven below stays 0.
    always_comb begin
        pc_we     = 1'b0;
        adr_src   = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        res_src   = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        imm_src   = 2'b00;
        alu_ctrl  = ALU_ADD;
        case (out_sel)
            S_FETCH: begin
                ir_we     = 1'b1;
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                pc_we     = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (bus.opcode == OP_JAL) ? 2'b11 : 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (bus.opcode == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                res_src = 2'b01;
                reg_we  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_we  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_decode(bus.funct3, bus.funct7_b5, 1'b1);
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_decode(bus.funct3, bus.funct7_b5, 1'b0);
            end
            S_ALUWB: begin
                reg_we = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_we     = bus.zero;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_we     = pc_we  & ~rst;
    assign bus.ir_we     = ir_we  & ~rst;
    assign bus.mem_we    = mem_we & ~rst;
    assign bus.reg_we    = reg_we & ~rst;
    assign bus.adr_src   = adr_src;
    assign bus.res_src   = res_src;
    assign bus.alu_src_a = alu_src_a;
    assign bus.alu_src_b = alu_src_b;
    assign bus.imm_src   = imm_src;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.state     = state_q;

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, raised on the DECODE->HALT transition.
    always_ff @(posedge clk) begin
        if (rst)                                          illegal_q <= 1'b0;
        else if (state_q == S_DECODE && state_d == S_HALT) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q & ~rst;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: directed instruction walks then randomized instruction
// streams, each compared against a step-list model of the control sequence.
module tb_riscv_mc_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    riscv_mc_ctrl_if bus ();
    riscv_mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [16:0] got;
    assign got = {bus.pc_we, bus.adr_src, bus.ir_we, bus.mem_we, bus.reg_we, bus.res_src,
                  bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_ctrl};

    function automatic logic [16:0] pk(logic pc, logic adr, logic ir, logic mem, logic rg,
                                       logic [1:0] res, logic [1:0] a, logic [1:0] b,
                                       logic [1:0] imm, logic [2:0] alu);
        return {pc, adr, ir, mem, rg, res, a, b, imm, alu};
    endfunction

    function automatic logic [2:0] alu_op(logic [2:0] f3, logic f7, bit is_r);
        if (f3 == 3'b000) return (is_r && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Datapath controls expected while the FSM sits in step st.
    function automatic logic [16:0] exp_out(int st, logic [6:0] op, logic [2:0] f3,
                                            logic f7, logic z);
        case (st)
            0:  return pk(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
            1:  return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, (op == JL) ? 2'b11 : 2'b10, 3'b000);
            2:  return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, (op == SW) ? 2'b01 : 2'b00, 3'b000);
            3:  return pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
            4:  return pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
            5:  return pk(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
            6:  return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu_op(f3, f7, 1));
            7:  return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu_op(f3, f7, 0));
            8:  return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
            9:  return pk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
            10: return pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000);
            default: return 17'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Step list the FSM should walk for one instruction, FETCH inclusive.
    task automatic build_seq(input logic [6:0] op, output int seq[$]);
        seq = {};
        case (op)
            LW: seq = {0, 1, 2, 3, 4};
            SW: seq = {0, 1, 2, 5};
            RT: seq = {0, 1, 6, 8};
            IT: seq = {0, 1, 7, 8};
            BQ: seq = {0, 1, 9};
            JL: seq = {0, 1, 10, 8};
            default: seq = TRAP ? '{0, 1, 11, 11, 11} : '{0, 1};
        endcase
    endtask

    // Reset for one edge; controls must show FETCH selects with enables off.
    task automatic do_reset(input string tag);
        logic [16:0] rvec;
        rvec = pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_out"}, got, rvec);
        chk({tag, "_rst_ill"}, 17'(bus.illegal), 17'd0);
        @(posedge clk); #1;
        chk({tag, "_rst_state"}, 17'(bus.state), 17'd0);
        chk({tag, "_rst_out2"}, got, rvec);
        rst = 1'b0;
    endtask

    // Walk one instruction (or its first max_steps steps), checking every cycle.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zf, input int max_steps);
        int   seq[$];
        int   n;
        logic z;
        build_seq(op, seq);
        n = (max_steps < 0 || max_steps > seq.size()) ? seq.size() : max_steps;
        bus.opcode = op; bus.funct3 = f3; bus.funct7_b5 = f7;
        for (int i = 0; i < n; i++) begin
            z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            bus.zero = z;
            @(negedge clk);
            chk($sformatf("%s_st%0d", tag, i), 17'(bus.state), 17'(seq[i]));
            chk($sformatf("%s_out%0d", tag, i), got, exp_out(seq[i], op, f3, f7, z));
            chk($sformatf("%s_ill%0d", tag, i), 17'(bus.illegal), 17'(seq[i] == 11));
            @(posedge clk); #1;
        end
        if (n == seq.size() && seq[n-1] == 11) do_reset({tag, "_halt"});
    endtask

    function automatic bit legal(logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
    endfunction

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        rst = 1'b1;
        bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_b5 = 1'b0; bus.zero = 1'b0;
        @(posedge clk); #1;
        do_reset("init");

        // Interrupt an R-type instruction in EXECR with a single reset edge.
        run_instr("pre_rst", RT, 3'b000, 1'b1, -1, 2);
        do_reset("execr");

        run_instr("ori",  IT, 3'b110, 1'b0, -1, -1);
        run_instr("lw",   LW, 3'b010, 1'b0, -1, -1);
        run_instr("sw",   SW, 3'b010, 1'b0, -1, -1);
        run_instr("sub",  RT, 3'b000, 1'b1, -1, -1);
        run_instr("add",  RT, 3'b000, 1'b0, -1, -1);
        run_instr("addi", IT, 3'b000, 1'b1, -1, -1);
        run_instr("slt",  RT, 3'b010, 1'b0, -1, -1);
        run_instr("and",  RT, 3'b111, 1'b0, -1, -1);
        run_instr("beq1", BQ, 3'b000, 1'b0, 1, -1);
        run_instr("beq0", BQ, 3'b000, 1'b0, 0, -1);
        run_instr("jal",  JL, 3'b000, 1'b0, -1, -1);
        run_instr("ill0", 7'b0000000, 3'b000, 1'b0, -1, -1);
        run_instr("after_ill", IT, 3'b111, 1'b0, -1, -1);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 6))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = IT;
                4: op = BQ;
                5: op = JL;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (legal(op)) op = 7'($urandom_range(0, 127));
                end
            endcase
            f3 = 3'($urandom_range(0, 7));
            run_instr($sformatf("rnd%0d", k), op, f3, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
